// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state encoding, widths and LFSR feedback for the lfsr_ctrl slice
package lfsr_pkg;
  localparam int W = 3;
  localparam int N = 4;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  function automatic logic [0:W-1] lfsr_next(input logic [0:W-1] q);
    return {q[2], q[0] ^ q[2], q[1]};
  endfunction
endpackage

// File: rtl/lfsr.sv
// lfsr: 3-bit LFSR register; ports Clock/Reset (sync, high), L loads R, en shifts once, Q is the state
module lfsr
  import lfsr_pkg::*;
(
  input  logic         Clock,
  input  logic         Reset,
  input  logic         L,
  input  logic         en,
  input  logic [0:W-1] R,
  output logic [0:W-1] Q
);
  always_ff @(posedge Clock)
    if (Reset) Q <= '0;
    else if (L) Q <= R;
    else if (en) Q <= lfsr_next(Q);
endmodule

// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: runs one LFSR job of nsteps shifts from seed; ports Clock/Reset, start/seed/nsteps in, Q/busy/done/err/wraps out
module lfsr_ctrl
  import lfsr_pkg::*;
(
  input  logic         Clock,
  input  logic         Reset,
  input  logic         start,
  input  logic [0:W-1] seed,
  input  logic [N-1:0] nsteps,
  output logic [0:W-1] Q,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   wraps
);
  state_t state, nxt;
  logic [0:W-1] seed_r;
  logic [N-1:0] steps_r, cnt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start ? LOAD : IDLE) :
          state == LOAD ? ((seed_r == '0 || steps_r == '0) ? DONE : RUN) :
          state == RUN  ? (cnt == N'(1) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge Clock)
    if (Reset) begin
      state   <= IDLE;
      seed_r  <= '0;
      steps_r <= '0;
      cnt     <= '0;
      wraps   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        seed_r  <= seed;
        steps_r <= nsteps;
      end
      if (state == LOAD) begin
        wraps <= '0;
        cnt   <= steps_r;
      end
      if (state == RUN) begin
        cnt <= cnt - N'(1);
        if (lfsr_next(Q) == seed_r && wraps != 2'd3) wraps <= wraps + 2'd1;
      end
    end
  assign busy = state == LOAD || state == RUN;
  assign done = state == DONE;
  assign err  = done && seed_r == '0;
  lfsr u_lfsr (
    .Clock(Clock),
    .Reset(Reset),
    .L(state == LOAD),
    .en(state == RUN),
    .R(seed_r),
    .Q(Q)
  );
endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb_lfsr_ctrl: randomized self-checking bench for lfsr_ctrl against an orbit-table model
module tb_lfsr_ctrl;
  logic clk = 0, rst = 1, start = 0;
  logic [0:2] seed = '0, q;
  logic [3:0] nsteps = '0;
  logic busy, done, err;
  logic [1:0] wraps;
  int checks = 0, errors = 0;
  logic [2:0] orbit [7] = '{3'b001, 3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010};

  lfsr_ctrl dut (
    .Clock(clk), .Reset(rst), .start(start), .seed(seed), .nsteps(nsteps),
    .Q(q), .busy(busy), .done(done), .err(err), .wraps(wraps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] adv(input logic [2:0] s, input int n);
    int p = 0;
    if (s == 3'b000) return 3'b000;
    for (int i = 0; i < 7; i++) if (orbit[i] == s) p = i;
    return orbit[(p + n) % 7];
  endfunction

  task automatic run_job(input logic [2:0] s, input logic [3:0] n, input bit extra);
    int d = 0, bc = 0, dexp;
    logic [2:0] qf;
    dexp = (s != 0 && n != 0) ? int'(n) + 1 : 1;
    start = 1; seed = s; nsteps = n;
    step();
    start = 0; seed = 3'($urandom); nsteps = 4'($urandom);
    while (!done && d < 20) begin
      if (busy) bc++;
      if (d >= 1) chk("q_run", 32'(q), 32'(adv(s, d - 1)));
      start = extra && d == 2;
      if (start) seed = 3'b111;
      step();
      d++;
    end
    start = 0;
    chk("latency", d, dexp);
    chk("busy_cycles", bc, dexp);
    qf = adv(s, int'(n));
    chk("q_final", 32'(q), 32'(qf));
    chk("wraps", 32'(wraps), (s == 0) ? 0 : int'(n) / 7);
    chk("err", 32'(err), 32'(s == 0));
    step();
    chk("done_pulse", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("q_hold", 32'(q), 32'(qf));
    chk("wraps_hold", 32'(wraps), (s == 0) ? 0 : int'(n) / 7);
  endtask

  initial begin
    rst = 1;
    start = 1; seed = 3'b111; nsteps = 4'd5;
    step(); step();
    chk("rst_q", 32'(q), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wraps", 32'(wraps), 0);
    start = 0; rst = 0;
    step();
    run_job(3'b001, 4'd7, 0);
    run_job(3'b001, 4'd3, 0);
    run_job(3'b000, 4'd5, 0);
    run_job(3'b101, 4'd0, 0);
    run_job(3'b010, 4'd14, 1);
    start = 1; seed = 3'b001; nsteps = 4'd15;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1;
    step();
    rst = 0;
    chk("midrun_q", 32'(q), 0);
    chk("midrun_busy", 32'(busy), 0);
    chk("midrun_done", 32'(done), 0);
    chk("midrun_wraps", 32'(wraps), 0);
    for (int i = 0; i < 20; i++) begin
      chk("no_done_after_rst", 32'(done), 0);
      step();
    end
    for (int j = 0; j < 40; j++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      run_job(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 Clock   input   1    single system clock; all state updates on rising edge.
REQ-002 Reset   input   1    synchronous, active-high reset; sampled on rising Clock edge.
REQ-003 start   input   1    request to run one job; sampled only in IDLE.
REQ-004 seed    input   [0:2]  LFSR seed; captured with start.
REQ-005 nsteps  input   [3:0]  number of LFSR shifts to perform (0..15); captured with start.
REQ-006 Q       output  [0:2]  current LFSR state, continuously driven from the internal LFSR.
REQ-007 busy    output  1    high in LOAD and RUN.
REQ-008 done    output  1    one-cycle pulse in DONE.
REQ-009 err     output  1    high in DONE when the captured seed was 3'b000; otherwise low.
REQ-010 wraps   output  [1:0]  count of returns of Q to the captured seed during RUN; valid in DONE, held in IDLE.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, RUN, DONE; encoding 2 bits.
REQ-012 IDLE: start=1 -> capture seed/nsteps, go to LOAD; start=0 -> stay.
REQ-013 LOAD: assert LFSR load (L=1, R=captured seed) for exactly one cycle; wraps<=0; remaining count<=nsteps.
REQ-014 LOAD exit: seed=000 or nsteps=0 -> DONE (no shift performed); else -> RUN.
REQ-015 RUN: each cycle LFSR shifts once (L=0), remaining count decrements; on edge where count=1 the last shift occurs and state -> DONE.
REQ-016 LFSR next-state: Q[0]<=Q[2]; Q[1]<=Q[0]^Q[2]; Q[2]<=Q[1] (period 7 for any nonzero seed).
REQ-017 LFSR SHALL hold its value in IDLE and DONE.
REQ-018 wraps SHALL increment when the post-shift Q equals the captured seed; saturates at 3 (cannot exceed 2 for nsteps<=15).
REQ-019 DONE lasts exactly one cycle, then -> IDLE; start in DONE is ignored.
REQ-020 start while busy SHALL be ignored; captured seed/nsteps not altered.
REQ-021 Latency: start sampled at edge k -> done high for the cycle after edge k+1+nsteps (nonzero seed, nsteps>=1); after edge k+1 when nsteps=0 or seed=000.
REQ-022 Q after completion SHALL equal seed advanced nsteps positions in the REQ-016 sequence.

Reset
REQ-023 Reset=1 at an edge -> state IDLE, Q=000, busy=0, done=0, err=0, wraps=00, count=0, captured registers 0.
REQ-024 Reset SHALL override start and any in-progress job, including mid-RUN; no done pulse follows.
REQ-025 Reset SHALL be synchronous only; no asynchronous paths.

Structure
REQ-026 Shared package lfsr_pkg SHALL hold state encoding constants (IDLE, LOAD, RUN, DONE), LFSR width 3, step-count width 4.
REQ-027 LFSR register and feedback SHALL be one sub-module, lfsr (ports R, L, Clock, Q, plus Reset), instantiated once; lfsr_ctrl contains FSM, counters, capture registers.

Verification
REQ-028 Reset, seed=001, nsteps=7, start 1 cycle -> busy 8 cycles, done 1 cycle, Q=001, wraps=01, err=0.
REQ-029 seed=001, nsteps=3 -> Q sequence 001,110,011,111; final Q=111, wraps=00.
REQ-030 seed=000, nsteps=5 -> LOAD then DONE; err=1, Q=000, wraps=00, no RUN cycles.
REQ-031 seed=101, nsteps=0 -> done 2 cycles after start sampled, Q=101, wraps=00, err=0.
REQ-032 seed=001, nsteps=15, Reset asserted on 4th RUN cycle -> next cycle IDLE, Q=000, busy=0, no done pulse.
REQ-033 seed=010, nsteps=14, second start with seed=111 mid-RUN -> ignored; final Q=010, wraps=10.
